filter_sample_scheduler: RTL and testbench

FILTER_SAMPLE_SCHEDULER -- requirements
Module: filter_sample_scheduler

---
 rtl/filter_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/filter_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_filter_sample_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_sched_pkg
//  Description : Shared definitions for the filter sample scheduler: default
//                parameter values and the scheduler FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_sched_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_TIMEOUT = 64;

  // Scheduler FSM: grant a channel, kick the core, wait for it, emit result.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

endpackage : filter_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. The channel following the
//                last granted one has the highest priority.
//  Ports       : req_i   - per-channel request vector
//                last_i  - index of the most recently granted channel
//                grant_o - one-hot grant (all-zero when nothing requests)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [NUM_CH-1:0] grant_o
);

  logic [CH_W-1:0]     w_shift;
  logic [2*NUM_CH-1:0] w_req_dbl;
  logic [NUM_CH-1:0]   w_req_rot;
  logic [NUM_CH-1:0]   w_gnt_rot;
  logic [2*NUM_CH-1:0] w_gnt_dbl;

  // Rotate so the highest-priority channel (last+1) lands at bit 0, pick the
  // lowest set bit, then rotate the one-hot result back.
  assign w_shift   = (last_i == CH_W'(NUM_CH - 1)) ? '0 : last_i + 1'b1;
  assign w_req_dbl = {req_i, req_i} >> w_shift;
  assign w_req_rot = w_req_dbl[NUM_CH-1:0];
  assign w_gnt_rot = w_req_rot & (~w_req_rot + NUM_CH'(1));
  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << w_shift;
  assign grant_o   = w_gnt_dbl[2*NUM_CH-1:NUM_CH];

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/filter_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : filter_sample_scheduler
//  Description : Time-shares one IIR filter core between NUM_CH sample
//                streams. Grants one channel round-robin, presents its sample
//                to the core, waits (bounded by TIMEOUT) for the result and
//                emits it tagged with the channel index.
//  Ports       : in_valid/in_data/in_ready - per-channel sample handshake
//                core_start/core_ch/core_in - request to the shared core
//                core_done/core_out          - result strobe from the core
//                out_valid/out_ch/out_data   - result strobe, no backpressure
//                timeout_err                 - sticky core-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_sample_scheduler
  import filter_sched_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     core_start,
  output logic [CH_W-1:0]          core_ch,
  output logic [DATA_W-1:0]        core_in,
  input  logic                     core_done,
  input  logic [DATA_W-1:0]        core_out,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     timeout_err
);

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q,   ptr_d;    // last granted channel
  logic [CNT_W-1:0]    cnt_q,   cnt_d;    // WAIT cycle counter
  logic [CH_W-1:0]     ch_q,    ch_d;     // channel of current transaction
  logic [DATA_W-1:0]   smp_q,   smp_d;    // sample presented to the core
  logic [DATA_W-1:0]   res_q,   res_d;    // core result awaiting output
  logic                err_q,   err_d;

  logic [NUM_CH-1:0]   w_grant;
  logic [CH_W-1:0]     w_gnt_idx;
  logic [DATA_W-1:0]   w_gnt_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req_i   (in_valid),
    .last_i  (ptr_q),
    .grant_o (w_grant)
  );

  // One-hot grant to index, and the matching sample.
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx  = CH_W'(i);
        w_gnt_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    smp_d   = smp_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|w_grant) begin
          ch_d    = w_gnt_idx;
          smp_d   = w_gnt_data;
          ptr_d   = w_gnt_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // core_done takes precedence over an expiring timeout.
        if (core_done) begin
          res_d   = core_out;
          state_d = ST_OUTPUT;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OUTPUT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(NUM_CH - 1);   // makes ch0 the first in line
      cnt_q   <= '0;
      ch_q    <= '0;
      smp_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      smp_q   <= smp_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Strobes are masked while reset is held so nothing leaks out before the
  // state register has been cleared.
  assign in_ready    = (state_q == ST_IDLE && !reset) ? w_grant : '0;
  assign core_start  = (state_q == ST_ISSUE)  && !reset;
  assign out_valid   = (state_q == ST_OUTPUT) && !reset;
  assign core_ch     = ch_q;
  assign core_in     = smp_q;
  assign out_ch      = ch_q;
  assign out_data    = res_q;
  assign timeout_err = err_q;

endmodule : filter_sample_scheduler
`default_nettype wire

// File: tb/tb_filter_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_sample_scheduler
//  Description : Self-checking bench for filter_sample_scheduler with a
//                behavioural IIR core model and an output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_sample_scheduler;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int TO = 64;
  localparam int CW = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     in_valid = '0;
  logic [NC*DW-1:0]  in_data = '0;
  logic [NC-1:0]     in_ready;
  logic              core_start;
  logic [CW-1:0]     core_ch;
  logic [DW-1:0]     core_in;
  logic              core_done;
  logic [DW-1:0]     core_out = '0;
  logic              out_valid;
  logic [CW-1:0]     out_ch;
  logic [DW-1:0]     out_data;
  logic              timeout_err;
  logic              model_done = 1'b0;
  logic              inj_done = 1'b0;

  assign core_done = model_done | inj_done;

  filter_sample_scheduler #(
    .DATA_W  (DW),
    .NUM_CH  (NC),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .core_start  (core_start),
    .core_ch     (core_ch),
    .core_in     (core_in),
    .core_done   (core_done),
    .core_out    (core_out),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; bit exp_out; } req_t;
  typedef struct { logic [CW-1:0] ch; logic [DW-1:0] data; } exp_t;

  req_t               chq[NC][$];
  exp_t               sb[$];
  int                 grant_log[$];
  int                 out_ch_log[$];
  logic signed [DW-1:0] ref_st[NC];
  logic signed [DW-1:0] core_st[NC];
  int                 ready_cnt[NC];
  int                 cyc = 0, ready_cyc = 0, start_cyc = 0, out_cyc = 0;
  logic [DW-1:0]      last_out_data = '0;
  int                 n_checks = 0, n_fail = 0;
  int                 lat = 1;
  bit                 rand_lat = 0, drop_next = 0, pend = 0;
  int                 cd = 0;
  logic [CW-1:0]      cch = '0;
  logic [DW-1:0]      cx = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference first-order IIR: y = x/2 + y_prev/4 (arithmetic shifts).
  function automatic logic signed [DW-1:0] iir_step(input logic signed [DW-1:0] x,
                                                   input logic signed [DW-1:0] st);
    return (x >>> 1) + (st >>> 2);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester driver + handshake monitor; expectations pushed on transfer.
  initial begin
    logic [NC-1:0] hs;
    forever begin
      @(negedge clk);
      hs = in_valid & in_ready;
      for (int k = 0; k < NC; k++) begin
        if (in_ready[k]) ready_cnt[k]++;
        if (hs[k]) begin
          grant_log.push_back(k);
          ready_cyc = cyc;
          if (chq[k][0].exp_out) begin
            exp_t e;
            ref_st[k] = iir_step(chq[k][0].data, ref_st[k]);
            e.ch   = CW'(k);
            e.data = ref_st[k];
            sb.push_back(e);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NC; k++) begin
        if (hs[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        in_valid[k] = (chq[k].size() > 0);
        in_data[k*DW +: DW] = (chq[k].size() > 0) ? chq[k][0].data : '0;
      end
    end
  end

  // Output monitor / scoreboard compare.
  initial forever begin
    @(negedge clk);
    if (out_valid) begin
      out_cyc = cyc;
      last_out_data = out_data;
      out_ch_log.push_back(int'(out_ch));
      if (sb.size() == 0) check_eq("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_ch", out_ch, e.ch);
        check_eq("out_data", out_data, e.data);
      end
    end
  end

  // Core model: capture request on core_start, answer after a latency.
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      start_cyc = cyc;
      if (drop_next) drop_next = 0;
      else begin
        pend = 1;
        cd   = rand_lat ? int'($urandom_range(1, 4)) : lat;
        cch  = core_ch;
        cx   = core_in;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        pend = 0;
        core_st[cch] = iir_step(cx, core_st[cch]);
        core_out = core_st[cch];
        model_done = 1'b1;
      end
    end
  end

  task automatic push_smp(input int ch, input logic [DW-1:0] d, input bit e);
    req_t r;
    r.data = d;
    r.exp_out = e;
    chq[ch].push_back(r);
  endtask

  task automatic clear_models();
    for (int k = 0; k < NC; k++) begin
      ref_st[k] = '0;
      core_st[k] = '0;
      ready_cnt[k] = 0;
    end
    grant_log.delete();
    out_ch_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((chq[0].size() > 0 || chq[1].size() > 0 || sb.size() > 0 || pend) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, 64'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    @(negedge clk);
    while (!core_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_start"}, core_start, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},   in_ready, 0);
    check_eq({tag, "_core_start"}, core_start, 0);
    check_eq({tag, "_out_valid"},  out_valid, 0);
    check_eq({tag, "_timeout"},    timeout_err, 0);
    check_eq({tag, "_core_in"},    core_in, 0);
    check_eq({tag, "_core_ch"},    core_ch, 0);
    check_eq({tag, "_out_ch"},     out_ch, 0);
    check_eq({tag, "_out_data"},   out_data, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  initial begin
    clear_models();
    do_reset();
    @(negedge clk);
    check_reset_outputs("rst");

    // Single channel, core answers two cycles after start.
    clear_models();
    lat = 2;
    push_smp(0, 32'sd1000, 1);
    drain("single", 200);
    check_eq("single_ready0_cycles", ready_cnt[0], 1);
    check_eq("single_ready1_cycles", ready_cnt[1], 0);
    check_eq("single_start_lat", start_cyc - ready_cyc, 1);
    check_eq("single_out_lat", out_cyc - start_cyc, 3);
    check_eq("single_out_data", last_out_data, 500);
    check_eq("single_out_count", out_ch_log.size(), 1);

    // Both channels valid straight out of reset: strict alternation from ch0.
    clear_models();
    lat = 1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_smp(0, -32'sd5, 1);
      push_smp(1, 32'sd7, 1);
    end
    do_reset();
    drain("alt", 500);
    check_eq("alt_grants", grant_log.size(), 8);
    check_eq("alt_outs", out_ch_log.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("alt_grant%0d", i), grant_log[i], i % 2);
      check_eq($sformatf("alt_outch%0d", i), out_ch_log[i], i % 2);
    end

    // Core never answers the first request: timeout, drop, then next grant.
    clear_models();
    do_reset();
    drop_next = 1;
    push_smp(0, 32'd111, 0);
    push_smp(1, 32'd222, 1);
    wait_start("to");
    repeat (TO) @(negedge clk);
    check_eq("to_flag_before", timeout_err, 0);
    @(negedge clk);
    check_eq("to_flag_set", timeout_err, 1);
    drain("to", 300);
    check_eq("to_grants", grant_log.size(), 2);
    check_eq("to_grant1", grant_log[1], 1);
    check_eq("to_outs", out_ch_log.size(), 1);
    check_eq("to_sticky", timeout_err, 1);

    // Stray core_done in IDLE and in ISSUE must be ignored.
    clear_models();
    do_reset();
    @(negedge clk);
    core_out = 32'd123;
    inj_done = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("idle_done_ready", in_ready, 0);
    check_eq("idle_done_start", core_start, 0);
    check_eq("idle_done_data", out_data, 0);
    lat = 3;
    push_smp(0, 32'd40, 1);
    wait_start("iss");
    core_out = 32'd999;
    inj_done = 1'b1;
    @(posedge clk);
    #1 inj_done = 1'b0;
    drain("iss", 200);
    check_eq("iss_out_lat", out_cyc - start_cyc, 4);
    check_eq("iss_out_data", last_out_data, 20);
    check_eq("iss_outs", out_ch_log.size(), 1);

    // Reset while waiting, late core_done afterwards, then ch0 priority.
    clear_models();
    do_reset();
    lat = 5;
    push_smp(0, 32'd77, 0);
    wait_start("rw");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rw");
    repeat (6) @(negedge clk);
    check_eq("rw_no_out", out_ch_log.size(), 0);
    clear_models();
    push_smp(0, 32'd5, 1);
    push_smp(1, 32'd6, 1);
    drain("rw", 200);
    check_eq("rw_first_grant", grant_log[0], 0);
    check_eq("rw_outs", out_ch_log.size(), 2);

    // Long alternating stream with random core latency.
    clear_models();
    do_reset();
    rand_lat = 1;
    for (int i = 0; i < 1000; i++) begin
      push_smp(0, $urandom, 1);
      push_smp(1, $urandom, 1);
    end
    drain("stream", 20000);
    check_eq("stream_outs", out_ch_log.size(), 2000);
    check_eq("stream_timeout", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_filter_sample_scheduler
`default_nettype wire
